ud_dir_detector: RTL and testbench

- Receiving end of the up/down counter interface: samples a free-running count bus, infers the direction the counter is actually moving, and drives the direction indicator on the 7-segment display.
- Sits downstream of the up/down counter (or an external counter on pins).
- Direction is only reported after a configurable number of consistent steps, so a hold, a reset or a jump never produces a false direction.

---
 rtl/ud_pkg.sv | 12 +
 rtl/ud_step_classify.sv | 28 ++
 rtl/ud_dir_detector.sv | 130 +++++++++++++
 tb/tb_ud_dir_detector.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/ud_pkg.sv
// Shared types and segment constants for the up/down direction detector.
package ud_pkg;

    typedef enum logic [1:0] {INIT, SEEK, LOCK_UP, LOCK_DOWN} state_t;
    typedef enum logic [1:0] {UP, DOWN, HOLD, JUMP} step_t;

    localparam logic [6:0] SS_UP    = 7'b0111110;
    localparam logic [6:0] SS_DOWN  = 7'b0111101;
    localparam logic [6:0] SS_BLANK = 7'b0000000;
    localparam logic [6:0] SS_FAULT = 7'b1001111;

endpackage

// File: rtl/ud_step_classify.sv
// Classifies one count step as UP, DOWN, HOLD or JUMP using modular distance.
// Purely combinational, zero latency, no flow control.
module ud_step_classify
    import ud_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] q_prev,
    output step_t            step
);

    logic [WIDTH-1:0] delta;

    // Modular subtraction makes wrap-around (max->0, 0->max) a legal single step.
    assign delta = q_in - q_prev;

    always_comb begin
        step = JUMP;
        if (delta == WIDTH'(1))
            step = UP;
        else if (delta == {WIDTH{1'b1}})
            step = DOWN;
        else if (delta == '0)
            step = HOLD;
    end

endmodule

// File: rtl/ud_dir_detector.sv
// Infers counter direction from a sampled count bus and drives a direction digit.
// One-cycle latency from a sample cycle; non-sample cycles hold all state.
// Optional UD_DIR_STEP_COUNT_EN adds a saturating locked-step counter output.
module ud_dir_detector
    import ud_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CONFIRM = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             sample,
    output logic             dir_up,
    output logic             dir_down,
    output logic             fault,
`ifdef UD_DIR_STEP_COUNT_EN
    output logic [7:0]       step_cnt,
`endif
    output logic [6:0]       ss
);

    localparam logic [3:0] CONF = 4'(CONFIRM);

    state_t           state, state_nxt;
    step_t            step;
    logic [WIDTH-1:0] q_prev;
    logic [3:0]       run, run_nxt;
    logic             run_up, run_up_nxt;
    logic             fault_nxt;
    logic [7:0]       cnt, cnt_nxt;
    logic [6:0]       ss_nxt;

    ud_step_classify #(.WIDTH(WIDTH)) u_classify (
        .q_in   (q_in),
        .q_prev (q_prev),
        .step   (step)
    );

    always_comb begin
        state_nxt  = state;
        run_nxt    = run;
        run_up_nxt = run_up;
        fault_nxt  = fault;
        cnt_nxt    = cnt;
        if (sample) begin
            fault_nxt = 1'b0;
            case (state)
                INIT: state_nxt = SEEK;
                SEEK: begin
                    case (step)
                        UP, DOWN: begin
                            if (run != 4'd0 && run_up == (step == UP))
                                run_nxt = (run >= CONF) ? run : run + 4'd1;
                            else begin
                                run_nxt    = 4'd1;
                                run_up_nxt = (step == UP);
                            end
                            if (run_nxt >= CONF)
                                state_nxt = run_up_nxt ? LOCK_UP : LOCK_DOWN;
                        end
                        HOLD: ;
                        default: begin
                            run_nxt   = 4'd0;
                            fault_nxt = 1'b1;
                        end
                    endcase
                end
                LOCK_UP, LOCK_DOWN: begin
                    // "with" is the step that keeps the current lock, "against" reverses it.
                    if ((state == LOCK_UP && step == UP) || (state == LOCK_DOWN && step == DOWN)) begin
                        if (cnt != 8'hFF)
                            cnt_nxt = cnt + 8'd1;
                    end else if (step == JUMP) begin
                        state_nxt = SEEK;
                        run_nxt   = 4'd0;
                        fault_nxt = 1'b1;
                        cnt_nxt   = 8'd0;
                    end else if (step != HOLD) begin
                        state_nxt  = SEEK;
                        run_nxt    = 4'd1;
                        run_up_nxt = (step == UP);
                        cnt_nxt    = 8'd0;
                    end
                end
                default: state_nxt = INIT;
            endcase
        end
    end

    always_comb begin
        ss_nxt = SS_BLANK;
        if (fault_nxt)
            ss_nxt = SS_FAULT;
        else if (state_nxt == LOCK_UP)
            ss_nxt = SS_UP;
        else if (state_nxt == LOCK_DOWN)
            ss_nxt = SS_DOWN;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= INIT;
            q_prev   <= '0;
            run      <= 4'd0;
            run_up   <= 1'b0;
            cnt      <= 8'd0;
            fault    <= 1'b0;
            dir_up   <= 1'b0;
            dir_down <= 1'b0;
            ss       <= SS_BLANK;
        end else begin
            state    <= state_nxt;
            run      <= run_nxt;
            run_up   <= run_up_nxt;
            cnt      <= cnt_nxt;
            fault    <= fault_nxt;
            dir_up   <= (state_nxt == LOCK_UP);
            dir_down <= (state_nxt == LOCK_DOWN);
            ss       <= ss_nxt;
            if (sample)
                q_prev <= q_in;
        end
    end

`ifdef UD_DIR_STEP_COUNT_EN
    assign step_cnt = cnt;
`endif

endmodule

// File: tb/tb_ud_dir_detector.sv
module tb_ud_dir_detector;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] q_in = 4'd0;
    logic       sample = 1'b0;
    logic       dir_up, dir_down, fault;
    logic [6:0] ss;
`ifdef UD_DIR_STEP_COUNT_EN
    logic [7:0] step_cnt;
`endif

    int checks = 0;
    int failures = 0;

    localparam logic [9:0] E_BLANK = {2'b00, 1'b0, 7'b0000000};
    localparam logic [9:0] E_UP    = {2'b10, 1'b0, 7'b0111110};
    localparam logic [9:0] E_DOWN  = {2'b01, 1'b0, 7'b0111101};
    localparam logic [9:0] E_FAULT = {2'b00, 1'b1, 7'b1001111};

    logic [9:0] obs;
    assign obs = {dir_up, dir_down, fault, ss};

    ud_dir_detector #(.WIDTH(4), .CONFIRM(2)) dut (
        .clk      (clk),
        .reset    (reset),
        .q_in     (q_in),
        .sample   (sample),
        .dir_up   (dir_up),
        .dir_down (dir_down),
        .fault    (fault),
`ifdef UD_DIR_STEP_COUNT_EN
        .step_cnt (step_cnt),
`endif
        .ss       (ss)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic s, input logic [3:0] v);
        @(negedge clk);
        sample = s;
        q_in   = v;
        @(posedge clk);
        #1;
        sample = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] vals [3] = '{4'd0, 4'd1, 4'd2};
        logic [9:0] exps [3] = '{E_BLANK, E_BLANK, E_UP};
        @(negedge clk);
        checks++;
        if (obs !== E_BLANK) begin
            failures++;
            $display("FAIL reset_state: got %b expected %b", obs, E_BLANK);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i]);
            checks++;
            if (obs !== exps[i]) begin
                failures++;
                $display("FAIL reset_hold step %0d: got %b expected %b", i, obs, exps[i]);
            end
        end
    endtask

    task automatic test_wrap_up();
        logic [3:0] vals [5] = '{4'd13, 4'd14, 4'd15, 4'd0, 4'd1};
        logic [9:0] exps [5] = '{E_BLANK, E_BLANK, E_UP, E_UP, E_UP};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, vals[i]);
            checks++;
            if (obs !== exps[i]) begin
                failures++;
                $display("FAIL wrap_up step %0d: got %b expected %b", i, obs, exps[i]);
            end
        end
    endtask

    task automatic test_reversal();
        // continues from lock-up at 1
        logic [3:0] vals [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3};
        logic [9:0] exps [6] = '{E_UP, E_UP, E_UP, E_UP, E_BLANK, E_DOWN};
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vals[i]);
            checks++;
            if (obs !== exps[i]) begin
                failures++;
                $display("FAIL reversal step %0d: got %b expected %b", i, obs, exps[i]);
            end
        end
    endtask

    task automatic test_jump();
        logic [3:0] vals [6] = '{4'd11, 4'd10, 4'd9, 4'd2, 4'd1, 4'd0};
        logic [9:0] exps [6] = '{E_BLANK, E_BLANK, E_DOWN, E_FAULT, E_BLANK, E_DOWN};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, vals[i]);
            checks++;
            if (obs !== exps[i]) begin
                failures++;
                $display("FAIL jump step %0d: got %b expected %b", i, obs, exps[i]);
            end
        end
    endtask

    task automatic test_hold_gating();
        do_reset();
        drive(1'b1, 4'd5);
        drive(1'b1, 4'd6);
        drive(1'b1, 4'd7);
        checks++;
        if (obs !== E_UP) begin
            failures++;
            $display("FAIL hold_lock: got %b expected %b", obs, E_UP);
        end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd7);
            checks++;
            if (obs !== E_UP) begin
                failures++;
                $display("FAIL hold_repeat %0d: got %b expected %b", i, obs, E_UP);
            end
        end
`ifdef UD_DIR_STEP_COUNT_EN
        checks++;
        if (step_cnt !== 8'd0) begin
            failures++;
            $display("FAIL step_cnt_hold: got %0d expected 0", step_cnt);
        end
`endif
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 4'($urandom_range(0, 15)));
            checks++;
            if (obs !== E_UP) begin
                failures++;
                $display("FAIL gating %0d: got %b expected %b", i, obs, E_UP);
            end
        end
        // q_prev must still be 7, so 8 is a clean UP step
        drive(1'b1, 4'd8);
        checks++;
        if (obs !== E_UP) begin
            failures++;
            $display("FAIL gating_resume: got %b expected %b", obs, E_UP);
        end
`ifdef UD_DIR_STEP_COUNT_EN
        checks++;
        if (step_cnt !== 8'd1) begin
            failures++;
            $display("FAIL step_cnt_inc: got %0d expected 1", step_cnt);
        end
`endif
    endtask

    task automatic test_async_reset();
        logic [3:0] vals [3] = '{4'd9, 4'd10, 4'd11};
        logic [9:0] exps [3] = '{E_BLANK, E_BLANK, E_UP};
        checks++;
        if (obs !== E_UP) begin
            failures++;
            $display("FAIL async_pre: got %b expected %b", obs, E_UP);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (obs !== E_BLANK) begin
            failures++;
            $display("FAIL async_immediate: got %b expected %b", obs, E_BLANK);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, vals[i]);
            checks++;
            if (obs !== exps[i]) begin
                failures++;
                $display("FAIL async_restart step %0d: got %b expected %b", i, obs, exps[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_reversal();
        test_jump();
        test_hold_gating();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
